mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port 16K x 32 instruction/data memory between two requesters: requester 0 (the CPU core) and requester 1 (the UART command processor).
- Each requester issues word read/write transfers with a req/gnt handshake.
- The block arbitrates between them using round-robin with a bounded hold window, registers the memory command, and returns read data tagged to the issuing requester after the memory latency.

Parameters:
- ADDR_W, 14, word address width.
- DATA_W, 32, data width.
- RD_LAT, 1, cycles from mem_addra being driven to mem_douta being valid; legal range 1..3.
- MAX_HOLD, 4, maximum consecutive accepted transfers by one requester while the other is requesting; legal range 1..15.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- m0_req  input  1  requester 0 transfer request
- m0_we  input  1  requester 0 write (1) / read (0)
- m0_addr  input  ADDR_W  requester 0 word address
- m0_wdata  input  DATA_W  requester 0 write data
- m0_gnt  output  1  requester 0 transfer accepted this cycle
- m0_rvalid  output  1  requester 0 read data valid
- m0_rdata  output  DATA_W  requester 0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as the m0 ports, for requester 1
- mem_wea  output  1  memory write enable
- mem_addra  output  ADDR_W  memory address
- mem_dina  output  DATA_W  memory write data
- mem_douta  input  DATA_W  memory read data
- busy  output  1  a transfer is issued or a read is outstanding

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. Reset clears mem_wea, mem_addra, mem_dina, busy, both gnt and both rvalid to 0. The last-served pointer resets to 1, so requester 0 wins the first tie. The hold counter resets to 0 and the read-tracking pipeline is flushed.
- Grant: combinational from req, the last-served pointer and the hold counter. At most one gnt is high per cycle, and gnt is never high without its req.
  - A transfer is accepted in cycle T when mX_req and mX_gnt are both high.
  - Requesters hold req, we, addr and wdata stable until gnt.
- Arbitration rules:
  - Only one requester requesting: it is granted every cycle (back-to-back transfers allowed).
  - Both requesting, hold counter < MAX_HOLD: grant goes to the last-served requester (continuation).
  - Both requesting, hold counter = MAX_HOLD: grant goes to the other requester.
  - Neither requesting: no grant; the pointer and counter hold.
- Hold counter:
  - Set to 1 on an accepted transfer from a requester that differs from last-served.
  - Incremented (saturating at MAX_HOLD) on an accepted transfer from last-served while the other requester's req is high.
  - Reset to 1 on an accepted transfer from last-served while the other requester's req is low.
  - Last-served updates on every accepted transfer.
- Memory command:
  - Registered. In cycle T+1, mem_addra = addr and mem_dina = wdata of the accepted transfer, and mem_wea = we for exactly one cycle.
  - With no acceptance in T, mem_wea = 0 at T+1 and mem_addra/mem_dina hold their previous values.
- Read return:
  - An accepted read (we=0) in T asserts mX_rvalid for exactly one cycle at T+1+RD_LAT, with mX_rdata = mem_douta in that cycle.
  - Tracking uses a (RD_LAT+1)-deep shift register of {valid, id}.
  - mX_rdata is don't-care when mX_rvalid is low, but is driven 0 in the implementation.
  - Writes produce no rvalid.
- Pipelining: reads and writes from either requester may be accepted every cycle. The return order equals the accept order, and the other requester's rvalid is never asserted for a transfer it did not issue.
- Read after write: a write accepted at T followed by a read of the same address accepted at T+1 returns the new data. This relies on the memory port write-then-read ordering; the arbiter adds no bypass.
- busy = (mem_wea) or (any tracking-pipeline stage valid).
- Reset mid-operation: all outstanding reads are discarded, and no rvalid is asserted in the cycles after rst deasserts.

Test Plan:
- Single write then read, RD_LAT=1:
  - Stimulus: m1 writes 0x0010 = 0xDEADBEEF; m1 reads 0x0010.
  - Required: mem_wea=1 for one cycle with mem_addra=0x0010; m1_rvalid high 2 cycles after the read gnt with m1_rdata=0xDEADBEEF; m0_rvalid stays 0.
- Tie after reset:
  - Stimulus: m0_req and m1_req both rise in the first cycle after reset.
  - Required: m0_gnt first.
- Starvation bound, MAX_HOLD=4:
  - Stimulus: m0 and m1 hold req continuously from cycle 0.
  - Required: grant pattern 0,0,0,0,1,1,1,1,0,...; never more than 4 consecutive grants to one requester.
- Back-to-back interleaved reads:
  - Stimulus: memory preloaded with addr0=0x11, addr1=0x22; m0 reads addr0, then m1 reads addr1 in consecutive cycles.
  - Required: m0_rvalid with 0x11 at T+2 and m1_rvalid with 0x22 at T+3; no cross-tagging.
- Solo streaming:
  - Stimulus: m0 alone requests 8 consecutive cycles.
  - Required: 8 consecutive m0_gnt; mem_wea/addr follow one cycle later.
- Reset mid-flight, RD_LAT=3:
  - Stimulus: rst asserted 1 cycle after a read gnt.
  - Required: no rvalid ever appears for that read; busy=0 after reset.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle for one port of mem_port_arbiter: word read/write
// request with req/gnt handshake and tagged read-data return.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port memory: round-robin with a bounded
// hold window, registered memory command, read data returned to its issuer.
module mem_port_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   m0,
    mem_port_arbiter_if.slave   m1,
    output logic                mem_wea,
    output logic [ADDR_W-1:0]   mem_addra,
    output logic [DATA_W-1:0]   mem_dina,
    input  logic [DATA_W-1:0]   mem_douta,
    output logic                busy
);
    localparam int HOLD_W = 4;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    typedef enum logic {SEL_M0 = 1'b0, SEL_M1 = 1'b1} sel_e;

    sel_e              last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              mem_wea_q, mem_wea_d;
    logic [ADDR_W-1:0] mem_addra_q, mem_addra_d;
    logic [DATA_W-1:0] mem_dina_q, mem_dina_d;
    logic [RD_LAT:0]   vld_q, vld_d;
    logic [RD_LAT:0]   id_q, id_d;

    logic              gnt0, gnt1, acc, acc_we, other_req;
    sel_e              win, acc_id;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    // A zero hold count only occurs straight out of reset; treating it as
    // "no continuation" lets the reset pointer of 1 hand the first tie to m0.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        win  = SEL_M0;
        if (m0.req && m1.req) begin
            if (hold_q != '0 && hold_q < HOLD_MAX) begin
                win = last_q;
            end else begin
                win = (last_q == SEL_M0) ? SEL_M1 : SEL_M0;
            end
            gnt0 = (win == SEL_M0);
            gnt1 = (win == SEL_M1);
        end else begin
            gnt0 = m0.req;
            gnt1 = m1.req;
        end
    end

    always_comb begin
        acc       = gnt0 | gnt1;
        acc_id    = gnt1 ? SEL_M1 : SEL_M0;
        acc_we    = gnt1 ? m1.we    : m0.we;
        acc_addr  = gnt1 ? m1.addr  : m0.addr;
        acc_wdata = gnt1 ? m1.wdata : m0.wdata;
        other_req = gnt1 ? m0.req   : m1.req;

        last_d = last_q;
        hold_d = hold_q;
        if (acc) begin
            last_d = acc_id;
            if (acc_id != last_q) begin
                hold_d = HOLD_W'(1);
            end else if (other_req) begin
                hold_d = (hold_q >= HOLD_MAX) ? HOLD_MAX : hold_q + HOLD_W'(1);
            end else begin
                hold_d = HOLD_W'(1);
            end
        end

        mem_wea_d   = acc & acc_we;
        mem_addra_d = acc ? acc_addr  : mem_addra_q;
        mem_dina_d  = acc ? acc_wdata : mem_dina_q;

        vld_d = {vld_q[RD_LAT-1:0], acc & ~acc_we};
        id_d  = {id_q[RD_LAT-1:0], acc_id == SEL_M1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= SEL_M1;
            hold_q      <= '0;
            mem_wea_q   <= 1'b0;
            mem_addra_q <= '0;
            mem_dina_q  <= '0;
            vld_q       <= '0;
            id_q        <= '0;
        end else begin
            last_q      <= last_d;
            hold_q      <= hold_d;
            mem_wea_q   <= mem_wea_d;
            mem_addra_q <= mem_addra_d;
            mem_dina_q  <= mem_dina_d;
            vld_q       <= vld_d;
            id_q        <= id_d;
        end
    end

    assign m0.gnt    = gnt0;
    assign m1.gnt    = gnt1;
    assign m0.rvalid = vld_q[RD_LAT] & ~id_q[RD_LAT];
    assign m1.rvalid = vld_q[RD_LAT] &  id_q[RD_LAT];
    assign m0.rdata  = m0.rvalid ? mem_douta : '0;
    assign m1.rdata  = m1.rvalid ? mem_douta : '0;

    assign mem_wea   = mem_wea_q;
    assign mem_addra = mem_addra_q;
    assign mem_dina  = mem_dina_q;
    assign busy      = mem_wea_q | (|vld_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RD_LAT=1 instance with memory model and read
// scoreboard, plus an RD_LAT=3 instance for reset during an outstanding read.
module tb_mem_port_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int HOLD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a0 ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a1 ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

    logic          a_wea, b_wea, a_busy, b_busy;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din, a_dout, b_dout;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_A), .MAX_HOLD(HOLD)) u_dut_a (
        .clk(clk), .rst(rst_a), .m0(a0), .m1(a1),
        .mem_wea(a_wea), .mem_addra(a_addr), .mem_dina(a_din), .mem_douta(a_dout), .busy(a_busy));

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_B), .MAX_HOLD(HOLD)) u_dut_b (
        .clk(clk), .rst(rst_b), .m0(b0), .m1(b1),
        .mem_wea(b_wea), .mem_addra(b_addr), .mem_dina(b_din), .mem_douta(b_dout), .busy(b_busy));

    // Initial memory contents: addr0=0x11, addr1=0x22, a pattern elsewhere.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        if (a == 0) return 32'h11;
        if (a == 1) return 32'h22;
        return {18'd0, a} ^ 32'h5A5A_0000;
    endfunction

    logic [DW-1:0] mem_a [int];
    always @(posedge clk) begin
        a_dout <= mem_a.exists(int'(a_addr)) ? mem_a[int'(a_addr)] : pat(a_addr);
        if (a_wea) mem_a[int'(a_addr)] = a_din;
    end

    logic [DW-1:0] b_p0, b_p1;
    always @(posedge clk) begin
        b_p0   <= pat(b_addr);
        b_p1   <= b_p0;
        b_dout <= b_p1;
    end

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rv0_cnt = 0, rv1_cnt = 0;
    logic [DW-1:0] shadow [int];
    logic          prev_acc = 1'b0, prev_we = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_din;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor for instance A: grant legality, memory command, read returns.
    always @(negedge clk) begin
        exp_t e;
        logic          acc, we, rv, id;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd, rd;
        if (rst_a) begin
            sb.delete();
            prev_acc = 1'b0;
        end else begin
            checks++;
            if ((a0.gnt && !a0.req) || (a1.gnt && !a1.req) || (a0.gnt && a1.gnt)) begin
                errors++;
                $display("FAIL gnt_legal: gnt0=%b gnt1=%b req0=%b req1=%b", a0.gnt, a1.gnt, a0.req, a1.req);
            end
            checks++;
            if (a_wea !== (prev_acc && prev_we)) begin
                errors++;
                $display("FAIL mem_wea: got %b exp %b", a_wea, prev_acc && prev_we);
            end
            if (prev_acc) begin
                checks++;
                if (a_addr !== prev_addr || (prev_we && a_din !== prev_din)) begin
                    errors++;
                    $display("FAIL mem_cmd: addr %h din %h exp addr %h din %h", a_addr, a_din, prev_addr, prev_din);
                end
            end
            for (int i = 0; i < 2; i++) begin
                rv = (i == 0) ? a0.rvalid : a1.rvalid;
                rd = (i == 0) ? a0.rdata  : a1.rdata;
                if (rv) begin
                    if (i == 0) rv0_cnt++; else rv1_cnt++;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL rv_unexpected: m%0d rvalid with data %h, none outstanding", i, rd);
                    end else begin
                        e = sb.pop_front();
                        if (e.id !== 1'(i) || e.data !== rd || e.due != cyc) begin
                            errors++;
                            $display("FAIL rv_return: m%0d data %h cyc %0d exp m%0d data %h cyc %0d",
                                     i, rd, cyc, e.id, e.data, e.due);
                        end
                    end
                end else begin
                    checks++;
                    if (rd !== '0) begin
                        errors++;
                        $display("FAIL rdata_idle: m%0d rdata %h exp 0", i, rd);
                    end
                end
            end
            acc = (a0.req && a0.gnt) || (a1.req && a1.gnt);
            id  = a1.req && a1.gnt;
            we  = id ? a1.we : a0.we;
            ad  = id ? a1.addr : a0.addr;
            wd  = id ? a1.wdata : a0.wdata;
            if (acc) begin
                if (we) begin
                    shadow[int'(ad)] = wd;
                end else begin
                    e.id   = id;
                    e.data = shadow.exists(int'(ad)) ? shadow[int'(ad)] : pat(ad);
                    e.due  = cyc + 1 + LAT_A;
                    sb.push_back(e);
                end
            end
            prev_acc  = acc;
            prev_we   = we;
            prev_addr = ad;
            prev_din  = wd;
        end
    end

    task automatic drive(input int id, input logic req, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        if (id == 0) begin
            a0.req = req; a0.we = we; a0.addr = addr; a0.wdata = wd;
        end else begin
            a1.req = req; a1.we = we; a1.addr = addr; a1.wdata = wd;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        b0.req = 1'b0; b0.we = 1'b0; b0.addr = '0; b0.wdata = '0;
        b1.req = 1'b0; b1.we = 1'b0; b1.addr = '0; b1.wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (a_wea !== 1'b0) begin errors++; $display("FAIL reset_wea: got %b exp 0", a_wea); end
        checks++; if (a_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h exp 0", a_addr); end
        checks++; if (a_din !== '0) begin errors++; $display("FAIL reset_din: got %h exp 0", a_din); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", a_busy); end
        checks++;
        if (a0.rvalid !== 1'b0 || a1.rvalid !== 1'b0 || a0.gnt !== 1'b0 || a1.gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_port: rv0=%b rv1=%b gnt0=%b gnt1=%b exp all 0", a0.rvalid, a1.rvalid, a0.gnt, a1.gnt);
        end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %b exp 0", b_busy); end
    endtask

    // Both requesters raise req in the first cycle after reset and hold it.
    task automatic test_starvation();
        logic exp1;
        step();
        rst_a = 1'b0;
        drive(0, 1'b1, 1'b0, 14'h0100, '0);
        drive(1, 1'b1, 1'b0, 14'h0200, '0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            exp1 = ((k / HOLD) % 2) == 1;
            checks++;
            if (a0.gnt !== !exp1 || a1.gnt !== exp1) begin
                errors++;
                $display("FAIL %s: cycle %0d gnt0=%b gnt1=%b exp gnt0=%b gnt1=%b",
                         (k == 0) ? "tie_first" : "hold_pattern", k, a0.gnt, a1.gnt, !exp1, exp1);
            end
            step();
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (4) step();
    endtask

    task automatic test_write_read();
        int  base0, base1;
        bit  got;
        base0 = rv0_cnt; base1 = rv1_cnt;
        got = 1'b0;
        drive(1, 1'b1, 1'b1, 14'h0010, 32'hDEAD_BEEF);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (a1.gnt) got = 1'b1; else step();
        end
        checks++;
        if (!got) begin errors++; $display("FAIL wr_gnt_timeout: gnt1=%b exp 1 within 20 cycles", a1.gnt); end
        step();
        drive(1, 1'b1, 1'b0, 14'h0010, '0);
        @(negedge clk);
        checks++;
        if (a_wea !== 1'b1 || a_addr !== 14'h0010 || a_din !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_cmd: wea %b addr %h din %h exp 1 0010 deadbeef", a_wea, a_addr, a_din);
        end
        checks++; if (a1.gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b exp 1", a1.gnt); end
        step();
        drive(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checks++; if (a_wea !== 1'b0) begin errors++; $display("FAIL wr_one_cycle: wea %b exp 0", a_wea); end
        step();
        @(negedge clk);
        checks++;
        if (a1.rvalid !== 1'b1 || a1.rdata !== 32'hDEAD_BEEF || a0.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL raw_return: rv1 %b rdata %h rv0 %b exp 1 deadbeef 0", a1.rvalid, a1.rdata, a0.rvalid);
        end
        repeat (3) step();
        checks++;
        if (rv0_cnt != base0 || rv1_cnt != base1 + 1) begin
            errors++;
            $display("FAIL wr_rd_counts: rv0 +%0d rv1 +%0d exp +0 +1", rv0_cnt - base0, rv1_cnt - base1);
        end
    endtask

    task automatic test_back_to_back();
        drive(0, 1'b1, 1'b0, 14'h0000, '0);
        @(negedge clk);
        checks++; if (a0.gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt0: got %b exp 1", a0.gnt); end
        step();
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b1, 1'b0, 14'h0001, '0);
        @(negedge clk);
        checks++; if (a1.gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt1: got %b exp 1", a1.gnt); end
        step();
        drive(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checks++;
        if (a0.rvalid !== 1'b1 || a0.rdata !== 32'h11 || a1.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ret0: rv0 %b rdata %h rv1 %b exp 1 00000011 0", a0.rvalid, a0.rdata, a1.rvalid);
        end
        @(negedge clk);
        checks++;
        if (a1.rvalid !== 1'b1 || a1.rdata !== 32'h22 || a0.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ret1: rv1 %b rdata %h rv0 %b exp 1 00000022 0", a1.rvalid, a1.rdata, a0.rvalid);
        end
        repeat (3) step();
    endtask

    task automatic test_solo_stream();
        int base0;
        for (int pass = 0; pass < 2; pass++) begin
            base0 = rv0_cnt;
            for (int i = 0; i <= 8; i++) begin
                if (i < 8) drive(0, 1'b1, pass == 0, 14'h0020 + 14'(i), 32'hC0DE_0000 + 32'(i));
                else       drive(0, 1'b0, 1'b0, '0, '0);
                @(negedge clk);
                if (i < 8) begin
                    checks++;
                    if (a0.gnt !== 1'b1) begin errors++; $display("FAIL solo_gnt: pass %0d beat %0d got %b exp 1", pass, i, a0.gnt); end
                end
                if (i > 0) begin
                    checks++;
                    if (a_wea !== (pass == 0) || a_addr !== 14'h0020 + 14'(i - 1)) begin
                        errors++;
                        $display("FAIL solo_cmd: pass %0d beat %0d wea %b addr %h exp %b %h",
                                 pass, i, a_wea, a_addr, pass == 0, 14'h0020 + 14'(i - 1));
                    end
                end
                step();
            end
            repeat (3) step();
            checks++;
            if (rv0_cnt != base0 + ((pass == 0) ? 0 : 8)) begin
                errors++;
                $display("FAIL solo_rv_count: pass %0d got +%0d exp +%0d", pass, rv0_cnt - base0, (pass == 0) ? 0 : 8);
            end
        end
    endtask

    task automatic test_reset_mid();
        rst_b = 1'b0;
        b0.req = 1'b1; b0.we = 1'b0; b0.addr = 14'h0033;
        @(negedge clk);
        checks++; if (b0.gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt: got %b exp 1", b0.gnt); end
        step();
        b0.req = 1'b0;
        rst_b = 1'b1;
        @(negedge clk);
        checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre: got %b exp 1", b_busy); end
        step();
        rst_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (b0.rvalid !== 1'b0 || b1.rvalid !== 1'b0 || b_busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_flush: cycle %0d rv0 %b rv1 %b busy %b exp 0 0 0", i, b0.rvalid, b1.rvalid, b_busy);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_starvation();
        test_write_read();
        test_back_to_back();
        test_solo_stream();
        test_reset_mid();
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d reads outstanding exp 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
